spike_event_decoder: RTL and testbench

Consumer of the membrane-potential stream produced by the linear Hodgkin-Huxley neuron core. Samples the signed 16-bit V output on a valid strobe and detects action potentials using a hysteresis threshold and a refractory window. Emits a one-cycle spike pulse, the inter-spike interval in samples, a saturating spike count and, optionally, the peak voltage of each spike. Sits between the neuron core's `data_out` and the chip output / readout logic.

---
 rtl/spike_event_decoder.sv | 250 +++++++++++++++++++++++++
 tb/tb_spike_event_decoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spike_event_decoder
// Description : Action-potential detector for the membrane-potential stream
//               of the linear Hodgkin-Huxley neuron core. Uses a hysteresis
//               threshold pair and a refractory window. It reports:
//                 - a one-cycle spike pulse
//                 - the inter-spike interval in samples
//                 - a saturating spike count
//                 - optionally, the peak voltage of each spike
//
// Parameters  : THRESH_HI        signed level that declares a spike (>=)
//               THRESH_LO        signed level that ends a spike (<=)
//               REFRACT_SAMPLES  valid samples ignored after a spike ends
//                                (0-255)
//
// Ports       : clock        rising-edge clock
//               reset        asynchronous, active-low reset
//               v_in         signed membrane potential sample
//               v_valid      v_in holds a new sample this cycle
//               spike        one-cycle pulse per detected spike
//               isi_out      samples between this crossing and the previous one
//               isi_valid    pulse with spike when isi_out is meaningful
//               spike_count  spikes since reset, saturating at 16'hFFFF
//               v_peak       signed maximum V of the most recently ended spike
//               peak_valid   one-cycle pulse when v_peak updates
//               in_refract   high while the refractory window is active
//
// Config      : SPIKE_PEAK_EN  when this macro is defined, the peak tracker is
//                              built and drives v_peak and peak_valid.
//                              When it is undefined, both outputs are tied
//                              to 0.
//
// Revision    : 1.0  initial release
// ============================================================================
module spike_event_decoder #(
    parameter logic signed [15:0] THRESH_HI       = 16'sd0,
    parameter logic signed [15:0] THRESH_LO       = -16'sd50,
    parameter int unsigned        REFRACT_SAMPLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [15:0] v_in,
    input  logic               v_valid,
    output logic               spike,
    output logic        [15:0] isi_out,
    output logic               isi_valid,
    output logic        [15:0] spike_count,
    output logic signed [15:0] v_peak,
    output logic               peak_valid,
    output logic               in_refract
);

    localparam logic [7:0]  c_ref_load = 8'(REFRACT_SAMPLES);
    localparam logic [15:0] c_sat      = 16'hFFFF;

    typedef enum logic [1:0] {
        BELOW   = 2'd0,
        ABOVE   = 2'd1,
        REFRACT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_isi_cnt;
    logic [15:0] w_isi_cnt_nxt;
    logic [7:0]  r_ref_cnt;
    logic [7:0]  w_ref_cnt_nxt;
    logic        r_first_seen;
    logic        w_first_seen_nxt;

    logic        r_spike;
    logic        w_spike_nxt;
    logic [15:0] r_isi_out;
    logic [15:0] w_isi_out_nxt;
    logic        r_isi_valid;
    logic        w_isi_valid_nxt;
    logic [15:0] r_spike_count;
    logic [15:0] w_spike_count_nxt;
    logic        r_in_refract;
    logic        w_in_refract_nxt;

    logic        w_crossing;
    logic [15:0] w_isi_plus;

`ifdef SPIKE_PEAK_EN
    logic signed [15:0] r_peak;
    logic signed [15:0] w_peak_nxt;
    logic signed [15:0] w_peak_max;
    logic signed [15:0] r_v_peak;
    logic signed [15:0] w_v_peak_nxt;
    logic               r_peak_valid;
    logic               w_peak_valid_nxt;

    assign w_peak_max = (v_in > r_peak) ? v_in : r_peak;
`endif

    // The ISI counts the crossing sample itself, so the reported interval is
    // the stored count plus one, held at full scale.
    assign w_isi_plus = (r_isi_cnt == c_sat) ? c_sat : (r_isi_cnt + 16'd1);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= BELOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_isi_cnt_nxt     = r_isi_cnt;
        w_ref_cnt_nxt     = r_ref_cnt;
        w_first_seen_nxt  = r_first_seen;
        w_spike_nxt       = 1'b0;
        w_isi_out_nxt     = r_isi_out;
        w_isi_valid_nxt   = 1'b0;
        w_spike_count_nxt = r_spike_count;
        w_crossing        = 1'b0;
`ifdef SPIKE_PEAK_EN
        w_peak_nxt        = r_peak;
        w_v_peak_nxt      = r_v_peak;
        w_peak_valid_nxt  = 1'b0;
`endif

        if (v_valid) begin
            case (r_state)
                BELOW: begin
                    if (v_in >= THRESH_HI) begin
                        w_crossing        = 1'b1;
                        w_state_nxt       = ABOVE;
                        w_spike_nxt       = 1'b1;
                        w_first_seen_nxt  = 1'b1;
                        w_spike_count_nxt = (r_spike_count == c_sat) ? c_sat
                                          : (r_spike_count + 16'd1);
                        // The first spike after reset has no reference
                        // crossing, so no interval is reported for it.
                        if (r_first_seen) begin
                            w_isi_out_nxt   = w_isi_plus;
                            w_isi_valid_nxt = 1'b1;
                        end
`ifdef SPIKE_PEAK_EN
                        w_peak_nxt = v_in;
`endif
                    end
                end

                ABOVE: begin
`ifdef SPIKE_PEAK_EN
                    w_peak_nxt = w_peak_max;
`endif
                    if (v_in <= THRESH_LO) begin
`ifdef SPIKE_PEAK_EN
                        w_v_peak_nxt     = w_peak_max;
                        w_peak_valid_nxt = 1'b1;
`endif
                        if (c_ref_load == 8'd0) begin
                            w_state_nxt = BELOW;
                        end else begin
                            w_state_nxt   = REFRACT;
                            w_ref_cnt_nxt = c_ref_load;
                        end
                    end
                end

                REFRACT: begin
                    // The sample that empties the window is itself masked.
                    // Detection resumes with the following sample.
                    w_ref_cnt_nxt = r_ref_cnt - 8'd1;
                    if (r_ref_cnt <= 8'd1) begin
                        w_ref_cnt_nxt = 8'd0;
                        w_state_nxt   = BELOW;
                    end
                end

                default: begin
                    w_state_nxt = BELOW;
                end
            endcase

            if (w_crossing) begin
                w_isi_cnt_nxt = 16'd0;
            end else if (r_isi_cnt != c_sat) begin
                w_isi_cnt_nxt = r_isi_cnt + 16'd1;
            end
        end

        w_in_refract_nxt = (w_state_nxt == REFRACT);
    end

    // ------------------------------------------------------------------------
    // Counters and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_isi_cnt     <= 16'd0;
            r_ref_cnt     <= 8'd0;
            r_first_seen  <= 1'b0;
            r_spike       <= 1'b0;
            r_isi_out     <= 16'd0;
            r_isi_valid   <= 1'b0;
            r_spike_count <= 16'd0;
            r_in_refract  <= 1'b0;
        end else begin
            r_isi_cnt     <= w_isi_cnt_nxt;
            r_ref_cnt     <= w_ref_cnt_nxt;
            r_first_seen  <= w_first_seen_nxt;
            r_spike       <= w_spike_nxt;
            r_isi_out     <= w_isi_out_nxt;
            r_isi_valid   <= w_isi_valid_nxt;
            r_spike_count <= w_spike_count_nxt;
            r_in_refract  <= w_in_refract_nxt;
        end
    end

`ifdef SPIKE_PEAK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_peak       <= 16'sd0;
            r_v_peak     <= 16'sd0;
            r_peak_valid <= 1'b0;
        end else begin
            r_peak       <= w_peak_nxt;
            r_v_peak     <= w_v_peak_nxt;
            r_peak_valid <= w_peak_valid_nxt;
        end
    end

    assign v_peak     = r_v_peak;
    assign peak_valid = r_peak_valid;
`else
    assign v_peak     = 16'sd0;
    assign peak_valid = 1'b0;
`endif

    assign spike       = r_spike;
    assign isi_out     = r_isi_out;
    assign isi_valid   = r_isi_valid;
    assign spike_count = r_spike_count;
    assign in_refract  = r_in_refract;

endmodule
`default_nettype wire

// File: tb/tb_spike_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_event_decoder
// Description : Self-checking bench for spike_event_decoder. Directed
//               scenarios followed by randomized samples, valid gaps and
//               asynchronous resets. All stimulus is scored against a
//               sample-level reference model. That model measures the ISI
//               as a difference of sample indices.
// Revision    : 1.0  initial release
// ============================================================================
module tb_spike_event_decoder;

    localparam int c_hi  = 0;
    localparam int c_lo  = -50;
    localparam int c_ref = 4;

    logic               clock;
    logic               reset;
    logic signed [15:0] v_in;
    logic               v_valid;
    logic               spike;
    logic        [15:0] isi_out;
    logic               isi_valid;
    logic        [15:0] spike_count;
    logic signed [15:0] v_peak;
    logic               peak_valid;
    logic               in_refract;

    spike_event_decoder #(
        .THRESH_HI       (16'sd0),
        .THRESH_LO       (-16'sd50),
        .REFRACT_SAMPLES (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .v_in        (v_in),
        .v_valid     (v_valid),
        .spike       (spike),
        .isi_out     (isi_out),
        .isi_valid   (isi_valid),
        .spike_count (spike_count),
        .v_peak      (v_peak),
        .peak_valid  (peak_valid),
        .in_refract  (in_refract)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk;
    int n_err;

    // ---------------- reference model state ----------------
    bit m_active;     // inside a spike (crossed up, not yet ended)
    int m_ref_left;   // masked samples still to come
    int m_count;
    int m_idx;        // index of the next valid sample since reset
    int m_last;       // index of the previous crossing, -1 if none
    int m_peak;

    int e_spike, e_isi_valid, e_isi_out, e_count, e_vpeak, e_pvalid, e_refr;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active    = 0;
        m_ref_left  = 0;
        m_count     = 0;
        m_idx       = 0;
        m_last      = -1;
        m_peak      = 0;
        e_spike     = 0;
        e_isi_valid = 0;
        e_isi_out   = 0;
        e_count     = 0;
        e_vpeak     = 0;
        e_pvalid    = 0;
        e_refr      = 0;
    endtask

    task automatic model_sample(input bit vv, input int v);
        int cur;
        e_spike     = 0;
        e_isi_valid = 0;
        e_pvalid    = 0;
        if (vv) begin
            cur   = m_idx;
            m_idx = m_idx + 1;
            if (m_ref_left > 0) begin
                m_ref_left = m_ref_left - 1;
            end else if (!m_active) begin
                if (v >= c_hi) begin
                    e_spike = 1;
                    m_count = (m_count < 65535) ? m_count + 1 : 65535;
                    if (m_last >= 0) begin
                        e_isi_valid = 1;
                        e_isi_out   = (cur - m_last > 65535) ? 65535 : cur - m_last;
                    end
                    m_last   = cur;
                    m_active = 1;
                    m_peak   = v;
                end
            end else begin
                if (v > m_peak) m_peak = v;
                if (v <= c_lo) begin
                    e_vpeak    = m_peak;
                    e_pvalid   = 1;
                    m_active   = 0;
                    m_ref_left = c_ref;
                end
            end
            e_count = m_count;
            e_refr  = (m_ref_left > 0) ? 1 : 0;
        end
    endtask

    task automatic check_outputs();
        chk("spike",       {15'd0, spike},       16'(e_spike));
        chk("isi_valid",   {15'd0, isi_valid},   16'(e_isi_valid));
        chk("isi_out",     isi_out,              16'(e_isi_out));
        chk("spike_count", spike_count,          16'(e_count));
        chk("in_refract",  {15'd0, in_refract},  16'(e_refr));
`ifdef SPIKE_PEAK_EN
        chk("v_peak",      v_peak,               16'(e_vpeak));
        chk("peak_valid",  {15'd0, peak_valid},  16'(e_pvalid));
`else
        chk("v_peak",      v_peak,               16'd0);
        chk("peak_valid",  {15'd0, peak_valid},  16'd0);
`endif
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked
    // 1 time unit after the edge that captured the sample.
    task automatic step(input bit vv, input int v);
        v_valid = vv;
        v_in    = 16'(v);
        model_sample(vv, v);
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        #2;
        check_outputs();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(1, -65);
    endtask

    initial begin
        int rv;
        n_chk   = 0;
        n_err   = 0;
        reset   = 1'b1;
        v_valid = 1'b0;
        v_in    = '0;
        model_reset();
        #3;
        do_reset();

        // Scenario 1: single spike with peak and refractory window
        step(1, -65);
        step(1, -20);
        step(1, 5);
        chk("s1_spike", {15'd0, spike}, 16'd1);
        chk("s1_isi_valid", {15'd0, isi_valid}, 16'd0);
        step(1, 30);
        step(1, 10);
        step(1, -60);
`ifdef SPIKE_PEAK_EN
        chk("s1_v_peak", v_peak, 16'd30);
`endif
        for (int i = 0; i < 4; i++) begin
            chk("s1_in_refract", {15'd0, in_refract}, 16'd1);
            step(1, -65);
        end
        chk("s1_refract_done", {15'd0, in_refract}, 16'd0);
        chk("s1_count", spike_count, 16'd1);

        // Scenario 2: ISI between crossings at indices 10 and 60
        do_reset();
        for (int i = 0; i <= 60; i++) step(1, (i == 10 || i == 60) ? 5 : -65);
        chk("s2_isi_out", isi_out, 16'd50);
        chk("s2_isi_valid", {15'd0, isi_valid}, 16'd1);
        quiet(8);

        // Scenario 3: refractory masking
        do_reset();
        step(1, 20);
        step(1, -60);
        for (int i = 0; i < 4; i++) begin
            step(1, 20);
            chk("s3_masked", {15'd0, spike}, 16'd0);
        end
        step(1, 20);
        chk("s3_spike", {15'd0, spike}, 16'd1);
        chk("s3_count", spike_count, 16'd2);
        quiet(8);

        // Scenario 4: hysteresis
        do_reset();
        step(1, 5);
        step(1, -30);
        step(1, 10);
        step(1, -40);
        chk("s4_no_peak", {15'd0, peak_valid}, 16'd0);
        step(1, -55);
`ifdef SPIKE_PEAK_EN
        chk("s4_v_peak", v_peak, 16'd10);
`endif
        chk("s4_count", spike_count, 16'd1);
        quiet(8);

        // Scenario 5: valid gaps during ABOVE, then reset mid-spike
        do_reset();
        quiet(3);
        step(1, 20);
        for (int i = 0; i < 6; i++) step(i % 2, (i % 2) ? 5 : -80);
        chk("s5_no_end", {15'd0, in_refract}, 16'd0);
        do_reset();
        quiet(2);
        step(1, 15);
        chk("s5_isi_valid", {15'd0, isi_valid}, 16'd0);
        chk("s5_count", spike_count, 16'd1);
        quiet(8);

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                rv = int'($urandom_range(0, 200)) - 100;
                if ($urandom_range(0, 29) == 0) rv = int'($signed(16'($urandom)));
                step($urandom_range(0, 3) != 0, rv);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
